// File: rtl/core101_pkg.sv
// Shared Core101 fetch types and defaults.
package core101_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO; flush has priority over push and pop.
module ifu_fifo
    import core101_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Core101 instruction fetch unit: pipelined requests, prefetch FIFO, redirect flush.
module ifu_prefetch
    import core101_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF,
    parameter int DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_addr_in,
    output logic            ins_mem_req_out,
    output logic [XLEN-1:0] ins_mem_addr_out,
    input  logic            ins_mem_ack_in,
    input  logic            ins_mem_valid_in,
    input  logic [ILEN-1:0] ins_mem_data_in,
    output logic            ins_valid_out,
    output logic [ILEN-1:0] ins_data_out,
    output logic [XLEN-1:0] ins_pc_out,
    input  logic            ins_ready_in,
    output logic            protocol_err_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            err_q, err_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN+ILEN-1:0] fifo_rdata;
    logic            push;
    logic            pop;
    logic            accept;
    logic            resp_ok;
    logic            redirect;
    logic [CW-1:0]   eff_out;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] target;

    assign target     = redirect_addr_in & ~XLEN'(3);
    assign redirect   = redirect_valid_in && (state_q != IDLE);
    assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding_q};

    assign ins_mem_req_out  = (state_q == FETCH) &&
                              (outstanding_q < CW'(MAX_OUTSTANDING)) &&
                              (credit_sum < (CW+1)'(DEPTH));
    assign ins_mem_addr_out = fetch_pc_q;
    assign accept           = ins_mem_req_out && ins_mem_ack_in;
    // A response with nothing outstanding is a protocol error and never counts.
    assign resp_ok          = ins_mem_valid_in && (outstanding_q != '0);
    assign eff_out          = outstanding_q + CW'(accept) - CW'(resp_ok);

    // The credit rule already prevents push-on-full; the full gate only protects FIFO state.
    assign push = (state_q == FETCH) && resp_ok && !redirect && !fifo_full;
    assign pop  = !fifo_empty && ins_ready_in && !redirect;

    assign ins_valid_out    = !fifo_empty;
    assign ins_pc_out       = fifo_empty ? '0 : fifo_rdata[XLEN+ILEN-1:ILEN];
    assign ins_data_out     = fifo_empty ? '0 : fifo_rdata[ILEN-1:0];
    assign protocol_err_out = err_q;

    ifu_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock_in),
        .rst   (reset_in),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({resp_pc_q, ins_mem_data_in}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and counter update; redirect overrides every other update.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = eff_out;
        discard_d     = discard_q;
        err_d         = err_q | (ins_mem_valid_in && (outstanding_q == '0));

        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            discard_d  = eff_out;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
            if (push)   resp_pc_d  = resp_pc_q + XLEN'(PC_INC);
            if ((state_q == DRAIN) && resp_ok && (discard_q != '0))
                discard_d = discard_q - CW'(1);
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (redirect && (eff_out != '0)) state_d = DRAIN;
            DRAIN:   if (!redirect && (discard_d == '0)) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed table-driven bench for ifu_prefetch with a streaming sequence at the end.
module tb_ifu_prefetch;

    logic        clk;
    logic        rst;
    logic        rv;
    logic [31:0] ra;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        mv;
    logic [31:0] md;
    logic        iv;
    logic [31:0] idata;
    logic [31:0] ipc;
    logic        rdy;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, rdy, ack, mv;
        logic [31:0] md;
        logic        rv;
        logic [31:0] ra;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tv[$];

    ifu_prefetch dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .redirect_valid_in (rv),
        .redirect_addr_in  (ra),
        .ins_mem_req_out   (req),
        .ins_mem_addr_out  (addr),
        .ins_mem_ack_in    (ack),
        .ins_mem_valid_in  (mv),
        .ins_mem_data_in   (md),
        .ins_valid_out     (iv),
        .ins_data_out      (idata),
        .ins_pc_out        (ipc),
        .ins_ready_in      (rdy),
        .protocol_err_out  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic y, input logic a, input logic v,
                       input logic [31:0] d, input logic x, input logic [31:0] t,
                       input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_pc, input logic [31:0] e_data, input logic e_err);
        vec_t v_;
        v_.rst = r;  v_.rdy = y;  v_.ack = a;  v_.mv = v;  v_.md = d;
        v_.rv = x;   v_.ra = t;
        v_.req = e_req; v_.addr = e_addr; v_.iv = e_iv; v_.pc = e_pc;
        v_.data = e_data; v_.err = e_err;
        tv.push_back(v_);
    endtask

    initial begin
        logic        pending;
        logic [31:0] paddr;
        logic        acc;
        logic [31:0] aaddr;
        logic        popv;
        logic [31:0] ppc;
        logic [31:0] pdata;
        logic [31:0] exp_pc;
        int          pops;

        rst = 1'b1; rv = 1'b0; ra = '0; ack = 1'b0; mv = 1'b0; md = '0; rdy = 1'b0;

        //  rst rdy ack mv  md            rv  ra      | req addr       iv pc          data          err
        // reset, release, streaming with 1-cycle memory latency
        add(1, 1, 1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,         0);
        add(1, 1, 1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 1, 32'hD0000000,  0, 32'h0,   1, 32'h8,   1, 32'h0,   32'hD0000000,  0);
        add(0, 1, 1, 1, 32'hD0000004,  0, 32'h0,   1, 32'hC,   1, 32'h4,   32'hD0000004,  0);
        add(0, 1, 1, 1, 32'hD0000008,  0, 32'h0,   1, 32'h10,  1, 32'h8,   32'hD0000008,  0);
        add(0, 1, 0, 1, 32'hD000000C,  0, 32'h0,   1, 32'h10,  1, 32'hC,   32'hD000000C,  0);
        add(0, 1, 0, 0, 32'h0,         0, 32'h0,   1, 32'h10,  0, 32'h0,   32'h0,         0);
        // decode stalled: exactly four requests, then one pop releases one more
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,   1, 32'h14,  0, 32'h0,   32'h0,         0);
        add(0, 0, 1, 1, 32'hD0000010,  0, 32'h0,   1, 32'h18,  1, 32'h10,  32'hD0000010,  0);
        add(0, 0, 1, 1, 32'hD0000014,  0, 32'h0,   1, 32'h1C,  1, 32'h10,  32'hD0000010,  0);
        add(0, 0, 1, 1, 32'hD0000018,  0, 32'h0,   0, 32'h20,  1, 32'h10,  32'hD0000010,  0);
        add(0, 0, 1, 1, 32'hD000001C,  0, 32'h0,   0, 32'h20,  1, 32'h10,  32'hD0000010,  0);
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 32'h20,  1, 32'h10,  32'hD0000010,  0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h20,  1, 32'h14,  32'hD0000014,  0);
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 32'h24,  1, 32'h14,  32'hD0000014,  0);
        add(0, 0, 1, 1, 32'hD0000020,  0, 32'h0,   0, 32'h24,  1, 32'h14,  32'hD0000014,  0);
        // redirect with nothing outstanding flushes a full FIFO and stays in fetch
        add(0, 0, 1, 0, 32'h0,         1, 32'h200, 1, 32'h200, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h204, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   0, 32'h208, 0, 32'h0,   32'h0,         0);
        // redirect to 0x103 with two outstanding: two drops, no requests while draining
        add(0, 1, 1, 0, 32'h0,         1, 32'h103, 0, 32'h100, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 1, 32'hD0000200,  0, 32'h0,   0, 32'h100, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 1, 32'hD0000204,  0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0,         0);
        add(0, 1, 0, 1, 32'hD0000100,  0, 32'h0,   1, 32'h104, 1, 32'h100, 32'hD0000100,  0);
        // redirect coinciding with a response, an accept and a pop
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,   1, 32'h108, 1, 32'h100, 32'hD0000100,  0);
        add(0, 1, 1, 1, 32'hD0000104,  1, 32'h300, 0, 32'h300, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 1, 32'hD0000108,  0, 32'h0,   1, 32'h300, 0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h304, 0, 32'h0,   32'h0,         0);
        add(0, 1, 0, 1, 32'hD0000300,  0, 32'h0,   1, 32'h304, 1, 32'h300, 32'hD0000300,  0);
        // stray response: sticky error, FIFO unchanged
        add(0, 0, 0, 1, 32'hDEADBEEF,  0, 32'h0,   1, 32'h304, 1, 32'h300, 32'hD0000300,  1);
        add(0, 0, 0, 0, 32'h0,         0, 32'h0,   1, 32'h304, 1, 32'h300, 32'hD0000300,  1);
        // fill to three entries, then reset mid-operation
        add(0, 0, 1, 0, 32'h0,         0, 32'h0,   1, 32'h308, 1, 32'h300, 32'hD0000300,  1);
        add(0, 0, 1, 1, 32'hD0000304,  0, 32'h0,   1, 32'h30C, 1, 32'h300, 32'hD0000300,  1);
        add(0, 0, 0, 1, 32'hD0000308,  0, 32'h0,   1, 32'h30C, 1, 32'h300, 32'hD0000300,  1);
        add(1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,         0);
        add(0, 1, 1, 0, 32'h0,         0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0,         0);

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; rdy = tv[i].rdy; ack = tv[i].ack; mv = tv[i].mv;
            md  = tv[i].md;  rv  = tv[i].rv;  ra  = tv[i].ra;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req", i),  {31'b0, req}, {31'b0, tv[i].req});
            chk($sformatf("v%0d addr", i), addr,         tv[i].addr);
            chk($sformatf("v%0d valid", i),{31'b0, iv},  {31'b0, tv[i].iv});
            chk($sformatf("v%0d pc", i),   ipc,          tv[i].pc);
            chk($sformatf("v%0d data", i), idata,        tv[i].data);
            chk($sformatf("v%0d err", i),  {31'b0, err}, {31'b0, tv[i].err});
        end

        // Streaming from address 0 with a latency-1 memory: decode sees consecutive PCs every cycle.
        pending = 1'b0;
        paddr   = '0;
        exp_pc  = '0;
        pops    = 0;
        rv = 1'b0; ra = '0;
        for (int k = 0; k < 20; k++) begin
            rdy   = 1'b1;
            ack   = 1'b1;
            mv    = pending;
            md    = 32'hD0000000 | paddr;
            acc   = req && ack;
            aaddr = addr;
            popv  = iv && rdy;
            ppc   = ipc;
            pdata = idata;
            @(posedge clk);
            #1;
            pending = acc;
            paddr   = aaddr;
            if (popv) begin
                chk($sformatf("stream pc%0d", pops), ppc, exp_pc);
                chk($sformatf("stream data%0d", pops), pdata, 32'hD0000000 | exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        chk("stream pops", 32'(pops), 32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit for Core101 that replaces the single-word IFU stub. Holds the fetch PC and issues pipelined requests on the instruction memory interface with several requests in flight. Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO and presents them to decode through a valid/ready handshake. Supports redirect (branch or jump) with a flush and stale-response discard.

Parameters:
XLEN, 32, address and PC width.
ILEN, 32, instruction word width.
DEPTH, 4, prefetch FIFO entries; must be a power of two, at least 2.
MAX_OUTSTANDING, 2, maximum accepted requests without responses; must be between 1 and DEPTH.
RESET_VECTOR, 32'h0000_0000, first fetch address after reset; low 2 bits must be 0.

Ports:
clock_in  input  1  core clock; all state updates on the rising edge.
reset_in  input  1  synchronous, active-high reset.
redirect_valid_in  input  1  flush the unit and restart fetch at redirect_addr_in.
redirect_addr_in  input  XLEN  redirect target; bits [1:0] ignored and forced to 0.
ins_mem_req_out  output  1  request valid.
ins_mem_addr_out  output  XLEN  request address, word aligned.
ins_mem_ack_in  input  1  request accepted this cycle when req and ack are both high.
ins_mem_valid_in  input  1  response valid; responses return in request order.
ins_mem_data_in  input  ILEN  response instruction word.
ins_valid_out  output  1  FIFO head is valid.
ins_data_out  output  ILEN  instruction at the FIFO head.
ins_pc_out  output  XLEN  PC of ins_data_out.
ins_ready_in  input  1  decode pops the head when valid and ready are both high.
protocol_err_out  output  1  sticky flag; set by a response arriving with no request outstanding.

Behaviour:
- Reset: fetch_pc and resp_pc load RESET_VECTOR. FIFO is emptied. outstanding and discard_cnt load 0. State is IDLE. All outputs are 0 except ins_mem_addr_out, which equals RESET_VECTOR.
- States: IDLE, FETCH, DRAIN.
  - IDLE to FETCH on the first cycle with reset_in low. No request is issued in IDLE.
  - FETCH to DRAIN on a redirect while effective outstanding is nonzero. Otherwise FETCH stays in FETCH.
  - DRAIN to FETCH when discard_cnt reaches 0 and no redirect is present.
- Request: ins_mem_req_out = (state == FETCH) && outstanding < MAX_OUTSTANDING && fifo_count + outstanding < DEPTH. This credit rule guarantees every response has a free FIFO slot.
- ins_mem_addr_out = fetch_pc. On each accepted request, fetch_pc increments by 4 and wraps modulo 2^XLEN. Requests may be issued back to back every cycle.
- outstanding updates each cycle as +1 for an accepted request and -1 for a response; both in the same cycle leave it unchanged.
- Accepted response in FETCH: {resp_pc, data} is written to the FIFO and resp_pc increments by 4. The entry is visible on ins_valid_out the next cycle; there is no bypass path, so fetch-to-decode latency is at least 2 cycles.
- Redirect, in any state other than IDLE, has highest priority:
  - fetch_pc and resp_pc load the aligned target.
  - The FIFO is flushed, and a pop in the same cycle is ignored.
  - discard_cnt loads the effective outstanding count: outstanding + this cycle's accept - this cycle's response.
  - A response arriving in the redirect cycle is dropped.
  - A request accepted in the redirect cycle is counted as stale.
- DRAIN: no requests are issued. Each response decrements discard_cnt and is dropped. A redirect during DRAIN reloads discard_cnt by the same rule and updates the PCs.
- FIFO full and push cannot coincide; this is guaranteed by the credit rule. Push and pop of a full or nonempty FIFO in the same cycle is allowed, and the count is unchanged.
- Holding ins_ready_in at 0 stalls issue once fifo_count + outstanding = DEPTH. Issue resumes the cycle after a pop.
- A response with outstanding = 0 sets protocol_err_out, which is cleared only by reset. The response is dropped.
- Reset asserted mid-operation discards everything. Responses to requests issued before reset are the environment's responsibility and are not tracked.

Decomposition:
- core101_pkg holds:
  - XLEN/ILEN defaults;
  - the fetch state enum {IDLE, FETCH, DRAIN};
  - the PC increment constant 4;
  - RESET_VECTOR default.
- Sub-module ifu_fifo: synchronous FIFO, width XLEN+ILEN, depth DEPTH, with push/pop/flush, count, full and empty. The flush input has priority over push and pop.

Test Plan:
- Reset release with ready=1, ack=1 and a memory latency of 1 → first request at address 0x0 two cycles after reset deasserts. Addresses then run 0x0, 0x4, 0x8. Decode sees PCs 0x0, 0x4, 0x8 with matching data, one per cycle at steady state.
- ins_ready_in=0 with DEPTH=4 and MAX_OUTSTANDING=2 → exactly 4 requests are issued, then req stays 0. One pop produces exactly one new request.
- Redirect to 0x103 with 2 requests outstanding → the next 2 responses are dropped and there are no requests during DRAIN. The next request goes to 0x100, and the first delivered instruction has pc 0x100.
- Redirect in the same cycle as a response and an accept → discard_cnt equals the old outstanding count minus 1 plus 1, and the FIFO is empty the next cycle.
- A response with nothing outstanding → protocol_err_out goes to 1 and stays at 1 until reset, and the FIFO is unchanged.
- Reset asserted while the FIFO holds 3 entries → the next cycle has ins_valid_out=0, req=0 and addr=RESET_VECTOR.
